push_arbiter: RTL

Round controller directly upstream of the scorer. It synchronizes the two player push-buttons and times a pseudo-random lights-off delay before turning the lights on. It decides which player pushed first and issues the one-cycle `winrnd` pulse, with `right` and `leds_on` valid in that cycle, for the scorer to consume.

---
 rtl/tow_pkg.sv | 12 +
 rtl/sync2.sv | 13 +
 rtl/push_arbiter.sv | 65 ++++++
 3 files changed

// File: rtl/tow_pkg.sv
// tow_pkg: shared FSM encoding, LFSR constants and default timing for the round controller
package tow_pkg;
  typedef enum logic [1:0] {REL, DELAY, LIT, WIN} state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int DELAY_MIN_DEF  = 16;
  localparam int DELAY_BITS_DEF = 8;
  localparam int REL_CYCLES_DEF = 4;
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous push-button
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // metastability filter, cleared on reset
  always_ff @(posedge clk)
    if (rst) {m, q} <= 2'b00;
    else {m, q} <= {d, m};
endmodule

// File: rtl/push_arbiter.sv
// push_arbiter: times a random lights-off delay and arbitrates which player pushed first
module push_arbiter
  import tow_pkg::*;
#(
  parameter int DELAY_MIN  = DELAY_MIN_DEF,
  parameter int DELAY_BITS = DELAY_BITS_DEF,
  parameter int REL_CYCLES = REL_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  output logic leds_on,
  output logic winrnd,
  output logic right
);
  localparam int DW_RAW = $clog2(DELAY_MIN + 2 ** DELAY_BITS);
  localparam int DW     = DW_RAW > 1 ? DW_RAW : 1;
  localparam int RW_RAW = $clog2(REL_CYCLES + 1);
  localparam int RW     = RW_RAW > 1 ? RW_RAW : 1;
  state_t state, state_n;
  logic pbl_s, pbr_s, push, decide, pick_right, tie_last;
  logic [7:0] lfsr;
  logic [RW-1:0] rel_cnt;
  logic [DW-1:0] dly_cnt;
  sync2 u_sync_l (.clk(clk), .rst(rst), .d(pbl), .q(pbl_s));
  sync2 u_sync_r (.clk(clk), .rst(rst), .d(pbr), .q(pbr_s));
  assign push       = pbl_s | pbr_s;
  assign decide     = push && (state == DELAY || state == LIT);
  assign pick_right = (pbl_s && pbr_s) ? ~tie_last : pbr_s;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= REL;
    else state <= state_n;
  // next-state: release wait, delay countdown, lit wait, single win cycle
  always_comb begin
    state_n = state;
    unique case (state)
      REL:     state_n = (rel_cnt == RW'(REL_CYCLES)) ? DELAY : REL;
      DELAY:   state_n = push ? WIN : (dly_cnt == '0 ? LIT : DELAY);
      LIT:     state_n = push ? WIN : LIT;
      WIN:     state_n = REL;
    endcase
  end
  // the win pulse is exactly the WIN cycle
  always_comb winrnd = (state == WIN);
  // LFSR, counters, lights and push resolution
  always_ff @(posedge clk)
    if (rst) begin
      lfsr     <= LFSR_SEED;
      rel_cnt  <= '0;
      dly_cnt  <= '0;
      tie_last <= 1'b1;
      leds_on  <= 1'b0;
      right    <= 1'b0;
    end else begin
      lfsr     <= lfsr_next(lfsr);
      rel_cnt  <= (state == REL && !push) ? rel_cnt + RW'(rel_cnt != RW'(REL_CYCLES)) : '0;
      dly_cnt  <= (state == REL) ? DW'(DELAY_MIN) + DW'(lfsr[DELAY_BITS-1:0]) :
                  (state == DELAY && dly_cnt != '0) ? dly_cnt - 1'b1 : dly_cnt;
      leds_on  <= (state == WIN) ? 1'b0 : (state == DELAY && !push && dly_cnt == '0) ? 1'b1 : leds_on;
      right    <= decide ? pick_right : right;
      tie_last <= (decide && pbl_s && pbr_s) ? ~tie_last : tie_last;
    end
endmodule
